// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and stall/flush statistics
module fetch_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard,
   input  logic             br_taken,
   input  logic [31:0]      br_addr,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      pc,
   output logic [31:0]      if_id_instr,
   output logic [31:0]      if_id_pc,
   output logic             if_id_valid,
   output logic [5:0]       opcode,
   output logic [4:0]       dest,
   output logic [4:0]       src1,
   output logic [4:0]       src2,
   output logic [31:0]      imm,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [31:0] pc_q;
   logic [31:0] pc_next_seq;
   logic [31:0] br_target;

   assign pc_next_seq = pc_q + 32'd4;
   assign br_target   = {br_addr[31:2], 2'b00};

   // Redirect outranks freeze: a squashed fetch slot is never counted as a stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= PC_RESET;
         if_id_instr <= 32'h0;
         if_id_pc    <= 32'h0;
         if_id_valid <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else if (br_taken) begin
         pc_q        <= br_target;
         if_id_instr <= 32'h0;
         if_id_pc    <= 32'h0;
         if_id_valid <= 1'b0;
         if (!(&flush_cnt))
            flush_cnt <= flush_cnt + 1'b1;
      end else if (hazard) begin
         if (!(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
      end else begin
         pc_q        <= pc_next_seq;
         if_id_instr <= imem_rdata;
         if_id_pc    <= pc_next_seq;
         if_id_valid <= 1'b1;
      end
   end

   assign pc        = pc_q;
   assign imem_addr = pc_q;

   // An all-zero bubble decodes to opcode 0, which the controller treats as a NOP.
   assign opcode = if_id_instr[31:26];
   assign dest   = if_id_instr[25:21];
   assign src1   = if_id_instr[20:16];
   assign src2   = if_id_instr[15:11];
   assign imm    = {{16{if_id_instr[15]}}, if_id_instr[15:0]};

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: default parameters
   logic        rst, hazard, br_taken;
   logic [31:0] br_addr, imem_addr, imem_rdata, pc, if_id_instr, if_id_pc, imm;
   logic        if_id_valid;
   logic [5:0]  opcode;
   logic [4:0]  dest, src1, src2;
   logic [15:0] stall_cnt, flush_cnt;
   logic        use_ovr;
   logic [31:0] ovr_word;

   assign imem_rdata = use_ovr ? ovr_word : (32'h8000_0000 + imem_addr);

   fetch_stage dut_a (
      .clk(clk), .rst(rst), .hazard(hazard), .br_taken(br_taken), .br_addr(br_addr),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
      .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
      .opcode(opcode), .dest(dest), .src1(src1), .src2(src2), .imm(imm),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // DUT B: wrap-around reset PC, narrow counters
   logic        rst_b, hazard_b, br_taken_b;
   logic [31:0] br_addr_b, imem_addr_b, imem_rdata_b, pc_b, if_id_instr_b, if_id_pc_b, imm_b;
   logic        if_id_valid_b;
   logic [5:0]  opcode_b;
   logic [4:0]  dest_b, src1_b, src2_b;
   logic [3:0]  stall_cnt_b, flush_cnt_b;

   assign imem_rdata_b = 32'h8000_0000 + imem_addr_b;

   fetch_stage #(.PC_RESET(32'hFFFF_FFF8), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst_b), .hazard(hazard_b), .br_taken(br_taken_b), .br_addr(br_addr_b),
      .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b), .pc(pc_b),
      .if_id_instr(if_id_instr_b), .if_id_pc(if_id_pc_b), .if_id_valid(if_id_valid_b),
      .opcode(opcode_b), .dest(dest_b), .src1(src1_b), .src2(src2_b), .imm(imm_b),
      .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        hz;
      logic        br;
      logic [31:0] ba;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic [31:0] e_ifpc;
      logic        e_valid;
      logic [15:0] e_stall;
      logic [15:0] e_flush;
   } vec_t;

   vec_t vecs[14];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 32'h0,   32'h4,   32'h8000_0000, 32'h4,   1'b1, 16'd0, 16'd0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,   32'h8,   32'h8000_0004, 32'h8,   1'b1, 16'd0, 16'd0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0,   32'h8,   32'h8000_0004, 32'h8,   1'b1, 16'd1, 16'd0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,   32'h8,   32'h8000_0004, 32'h8,   1'b1, 16'd2, 16'd0};
      vecs[4]  = '{1'b1, 1'b0, 32'h0,   32'h8,   32'h8000_0004, 32'h8,   1'b1, 16'd3, 16'd0};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,   32'hC,   32'h8000_0008, 32'hC,   1'b1, 16'd3, 16'd0};
      vecs[6]  = '{1'b0, 1'b0, 32'h0,   32'h10,  32'h8000_000C, 32'h10,  1'b1, 16'd3, 16'd0};
      vecs[7]  = '{1'b0, 1'b1, 32'h103, 32'h100, 32'h0,         32'h0,   1'b0, 16'd3, 16'd1};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,   32'h104, 32'h8000_0100, 32'h104, 1'b1, 16'd3, 16'd1};
      vecs[9]  = '{1'b1, 1'b1, 32'h40,  32'h40,  32'h0,         32'h0,   1'b0, 16'd3, 16'd2};
      vecs[10] = '{1'b0, 1'b0, 32'h0,   32'h44,  32'h8000_0040, 32'h44,  1'b1, 16'd3, 16'd2};
      vecs[11] = '{1'b0, 1'b1, 32'h44,  32'h44,  32'h0,         32'h0,   1'b0, 16'd3, 16'd3};
      vecs[12] = '{1'b0, 1'b1, 32'h202, 32'h200, 32'h0,         32'h0,   1'b0, 16'd3, 16'd4};
      vecs[13] = '{1'b0, 1'b0, 32'h0,   32'h204, 32'h8000_0200, 32'h204, 1'b1, 16'd3, 16'd4};

      rst = 1'b1; hazard = 1'b0; br_taken = 1'b0; br_addr = 32'h0;
      use_ovr = 1'b0; ovr_word = 32'h0;
      rst_b = 1'b1; hazard_b = 1'b0; br_taken_b = 1'b0; br_addr_b = 32'h0;

      tick();
      tick();
      check("rst_pc", pc, 32'h0);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_instr", if_id_instr, 32'h0);
      check("rst_ifpc", if_id_pc, 32'h0);
      check("rst_valid", {31'h0, if_id_valid}, 32'h0);
      check("rst_stall", {16'h0, stall_cnt}, 32'h0);
      check("rst_flush", {16'h0, flush_cnt}, 32'h0);

      rst = 1'b0;
      for (int i = 0; i < 14; i++) begin
         hazard = vecs[i].hz; br_taken = vecs[i].br; br_addr = vecs[i].ba;
         tick();
         check($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
         check($sformatf("v%0d_instr", i), if_id_instr, vecs[i].e_instr);
         check($sformatf("v%0d_ifpc", i), if_id_pc, vecs[i].e_ifpc);
         check($sformatf("v%0d_valid", i), {31'h0, if_id_valid}, {31'h0, vecs[i].e_valid});
         check($sformatf("v%0d_stall", i), {16'h0, stall_cnt}, {16'h0, vecs[i].e_stall});
         check($sformatf("v%0d_flush", i), {16'h0, flush_cnt}, {16'h0, vecs[i].e_flush});
      end
      hazard = 1'b0; br_taken = 1'b0; br_addr = 32'h0;

      // Decode fields: negative immediate
      use_ovr = 1'b1; ovr_word = 32'hAC65_8004;
      tick();
      check("dec1_opcode", {26'h0, opcode}, 32'h2B);
      check("dec1_dest", {27'h0, dest}, 32'd3);
      check("dec1_src1", {27'h0, src1}, 32'd5);
      check("dec1_src2", {27'h0, src2}, 32'd16);
      check("dec1_imm", imm, 32'hFFFF_8004);
      // Decode fields: positive immediate
      ovr_word = 32'h0C22_7FFF;
      tick();
      check("dec2_opcode", {26'h0, opcode}, 32'h3);
      check("dec2_dest", {27'h0, dest}, 32'd1);
      check("dec2_src1", {27'h0, src1}, 32'd2);
      check("dec2_src2", {27'h0, src2}, 32'd15);
      check("dec2_imm", imm, 32'h0000_7FFF);
      // Bubble decodes as NOP
      use_ovr = 1'b0; br_taken = 1'b1; br_addr = 32'h300;
      tick();
      br_taken = 1'b0;
      check("bub_opcode", {26'h0, opcode}, 32'h0);
      check("bub_imm", imm, 32'h0);
      check("bub_pc", pc, 32'h300);
      tick();
      check("bub_next_instr", if_id_instr, 32'h8000_0300);

      // DUT B: PC wrap
      rst_b = 1'b0;
      check("b_rst_pc", pc_b, 32'hFFFF_FFF8);
      tick();
      check("b_wrap_pc1", pc_b, 32'hFFFF_FFFC);
      check("b_wrap_instr1", if_id_instr_b, 32'h7FFF_FFF8);
      tick();
      check("b_wrap_pc2", pc_b, 32'h0);
      check("b_wrap_ifpc2", if_id_pc_b, 32'h0);
      check("b_wrap_instr2", if_id_instr_b, 32'h7FFF_FFFC);
      check("b_wrap_valid2", {31'h0, if_id_valid_b}, 32'h1);

      // Stall saturation at 15 over a 20-cycle freeze
      hazard_b = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) check("b_stall_14", {28'h0, stall_cnt_b}, 32'd14);
         if (i == 15) check("b_stall_15", {28'h0, stall_cnt_b}, 32'd15);
      end
      check("b_stall_sat", {28'h0, stall_cnt_b}, 32'd15);
      check("b_freeze_pc", pc_b, 32'h0);

      // Reset mid-freeze
      rst_b = 1'b1;
      tick();
      check("b_rst2_pc", pc_b, 32'hFFFF_FFF8);
      check("b_rst2_stall", {28'h0, stall_cnt_b}, 32'd0);
      check("b_rst2_flush", {28'h0, flush_cnt_b}, 32'd0);
      check("b_rst2_valid", {31'h0, if_id_valid_b}, 32'h0);
      rst_b = 1'b0; hazard_b = 1'b0;

      // Flush saturation with back-to-back redirects
      br_taken_b = 1'b1; br_addr_b = 32'h1001;
      for (int i = 1; i <= 18; i++) tick();
      br_taken_b = 1'b0;
      check("b_flush_sat", {28'h0, flush_cnt_b}, 32'd15);
      check("b_flush_pc", pc_b, 32'h1000);
      check("b_flush_stall", {28'h0, stall_cnt_b}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. Sits directly upstream of the decode controller.
- Owns the PC, drives the instruction-memory address and captures the returned word into IF/ID.
- Presents the decoded instruction fields (opcode to the controller; register fields and immediate to the register file and ID/EX).
- Honours the hazard freeze and branch redirect, and keeps saturating stall/flush statistics counters.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the stall and flush statistics counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- hazard  input  1  freeze request from the hazard unit; same signal the controller receives.
- br_taken  input  1  branch/jump resolved taken; redirect the PC.
- br_addr  input  32  branch/jump target byte address.
- imem_addr  output  32  instruction-memory byte address; equals pc.
- imem_rdata  input  32  instruction word, combinational from imem_addr in the same cycle.
- pc  output  32  current fetch PC.
- if_id_instr  output  32  registered instruction; 32'h0 is a bubble.
- if_id_pc  output  32  registered PC+4 of the captured instruction.
- if_id_valid  output  1  IF/ID holds a real fetched instruction.
- opcode  output  6  if_id_instr[31:26]; feeds the controller.
- dest  output  5  if_id_instr[25:21].
- src1  output  5  if_id_instr[20:16].
- src2  output  5  if_id_instr[15:11].
- imm  output  32  if_id_instr[15:0], sign-extended.
- stall_cnt  output  CNT_W  number of cycles frozen by hazard.
- flush_cnt  output  CNT_W  number of branch redirects.

Behaviour:
- Priority each rising edge: rst > br_taken > hazard > normal advance.
- Reset:
  - pc = PC_RESET.
  - if_id_instr = 0, if_id_pc = 0, if_id_valid = 0.
  - stall_cnt = 0, flush_cnt = 0.
  - Reset asserted mid-run discards any in-flight redirect or freeze; there is no pending state.
- Normal (no rst, no br_taken, no hazard):
  - pc <= pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - if_id_instr <= imem_rdata, if_id_pc <= pc + 4, if_id_valid <= 1.
- Freeze (hazard=1, br_taken=0):
  - pc and all IF/ID registers hold.
  - stall_cnt increments, saturating at all-ones.
- Redirect (br_taken=1, regardless of hazard):
  - pc <= {br_addr[31:2], 2'b00}; low bits are forced to zero and misaligned targets are silently aligned.
  - IF/ID is flushed: if_id_instr <= 0, if_id_pc <= 0, if_id_valid <= 0.
  - flush_cnt increments, saturating.
  - stall_cnt does not increment that cycle, even if hazard=1.
- Latency:
  - Instruction at address A appears on if_id_instr the cycle after pc==A, provided that cycle is not frozen or flushed.
  - Branch penalty is one bubble: the target instruction reaches IF/ID one cycle after the redirect edge's bubble.
- Bubble:
  - An all-zero word decodes as opcode 000000, which the controller maps to all control signals 0 (NOP).
  - Flush therefore never produces a side effect downstream.
- Decode fields (opcode, dest, src1, src2, imm) are purely combinational from if_id_instr; no extra latency.
- imem_addr is combinational from pc; the stage never stalls on memory.
- Back-to-back redirects are each applied, and each increments flush_cnt.
- A redirect to the current pc value is still a flush.
- Counter saturation: once a counter reaches 2^CNT_W-1 it holds until rst.

Test Plan:
- Reset then free-run with imem returning 32'h8000_0000+addr → pc goes 0,4,8,12; if_id_instr lags one cycle; if_id_pc = 4,8,12; if_id_valid rises one cycle after rst falls.
- hazard high for 3 cycles at pc=8 → pc stays 8, if_id_instr unchanged for 3 cycles, stall_cnt = 3; fetch resumes at 8→12.
- br_taken with br_addr=32'h0000_0103 at pc=16 → next pc = 32'h100, if_id_instr = 0, valid = 0, flush_cnt = 1; the instruction from 0x100 appears one cycle later.
- br_taken and hazard together, br_addr=32'h40 → redirect wins: pc = 32'h40, IF/ID flushed, flush_cnt +1, stall_cnt unchanged.
- PC_RESET=32'hFFFF_FFF8, free-run → pc goes FFFF_FFF8, FFFF_FFFC, 0000_0000.
- CNT_W=4, hazard held 20 cycles, then rst pulsed mid-freeze → stall_cnt saturates at 15; after rst, pc = PC_RESET, counters = 0, valid = 0.
